rat_intr_ctrl: RTL and testbench
================================

Name: rat_intr_ctrl

Overview:
- Interrupt sequencer for the RAT CPU; it initiates the flag shadow save/restore protocol that the flags register responds to.
- Detects external INTR rising edges and holds the request pending. Raises INT_REQ to the control unit when the interrupt-enable flag is set.
- On the control unit's acknowledge, saves C/Z to the shadow. On RETID/RETIE, restores C/Z from the shadow and restores the I flag.
- Sits between the external interrupt pin, the control unit and the flags register.

Parameters:
- DROP_W, 8, width of the saturating dropped-interrupt counter.

Ports:
- CLK  in  1  system clock; all state changes on posedge CLK.
- RST_N  in  1  reset, asynchronous, active-low.
- INTR  in  1  external interrupt request, asynchronous, rising-edge significant.
- SEI  in  1  one-cycle pulse from the control unit: set I flag.
- CLI  in  1  one-cycle pulse from the control unit: clear I flag.
- INT_ACK  in  1  pulse from the control unit: interrupt cycle started.
- RETI  in  1  pulse from the control unit: RETID/RETIE executing.
- RETI_IE  in  1  I flag value for RETI (1 = RETIE, 0 = RETID).
- INT_REQ  out  1  interrupt request to the control unit.
- I_FLAG  out  1  interrupt-enable flag.
- IN_SERVICE  out  1  high while the ISR is active.
- FLG_SHAD_LD  out  1  shadow-save strobe to the flags register.
- FLG_LD_SEL  out  1  flags load source select (1 = shadow).
- FLG_C_LD  out  1  C flag load strobe.
- FLG_Z_LD  out  1  Z flag load strobe.
- DROP_CNT  out  DROP_W  saturating count of lost INTR edges.

Behaviour:
- Reset (RST_N low, asynchronous): state IDLE, pend_q 0, I_FLAG 0, DROP_CNT 0, synchronizer/edge registers 0. All strobe outputs 0.
- Edge detect: edge = intr_s & ~intr_s_d, where intr_s is INTR after the optional synchronizer.
- States (st_e):
  - IDLE: no request. Edge -> PEND.
  - PEND: request waiting. Accepted ack -> SERVICE.
  - SERVICE: ISR running. RETI -> PEND if pend_q, else IDLE.
- pend_q:
  - Set by an edge in any state.
  - Cleared by an accepted ack, unless a new edge arrives in the same cycle; that edge re-sets it as a new request.
- Dropped edges: an edge while pend_q is already 1 and no accepted ack that cycle -> DROP_CNT += 1. DROP_CNT saturates at all-ones; it never wraps.
- INT_REQ = (state == PEND) & I_FLAG; combinational from registers only. A pending request stays latched while I_FLAG = 0 and is served once SEI arrives.
- Accepted ack = INT_ACK & INT_REQ. INT_ACK with INT_REQ = 0 is ignored entirely.
- Ack cycle:
  - FLG_SHAD_LD = 1, combinational, so the shadow captures the current C/Z at that edge.
  - Next cycle: I_FLAG = 0, state SERVICE.
- Restore cycle (RETI & state == SERVICE):
  - FLG_LD_SEL = FLG_C_LD = FLG_Z_LD = 1, combinational, for exactly that cycle.
  - Next cycle: I_FLAG = RETI_IE, IN_SERVICE = 0.
- RETI outside SERVICE: ignored; no strobes, no I_FLAG change.
- Otherwise FLG_LD_SEL, FLG_C_LD, FLG_Z_LD = 0; the control unit ORs in its own ALU flag loads.
- I_FLAG update priority, same cycle: accepted ack > valid RETI > CLI > SEI.
- IN_SERVICE = (state == SERVICE).
- No nesting: INT_REQ is 0 in SERVICE regardless of I_FLAG.
- Latency, INTR rise to INT_REQ: 1 cycle without the synchronizer (edge registered into pend_q/state); 3 cycles with it.

Optional Feature:
- RAT_INTR_SYNC_EN defined: INTR passes a 2-flop synchronizer (reset to 0) before edge detect; latency +2 cycles.
- Not defined: INTR feeds edge detect directly; the source must already be synchronous to CLK.

Decomposition:
- Package rat_intr_pkg:
  - typedef enum logic [1:0] st_e {IDLE, PEND, SERVICE}.
  - Localparam for the synchronizer depth (2).
- One sub-module, rat_intr_sync: 2-flop synchronizer plus rising-edge detector, async active-low reset.
- All else lives in rat_intr_ctrl.

Test Plan:
- Reset with RST_N = 0 mid-SERVICE, asynchronously -> immediately IDLE; I_FLAG = 0, IN_SERVICE = 0, DROP_CNT = 0, all strobes 0.
- SEI, then INTR 0->1 -> INT_REQ = 1 after 1 cycle (3 with RAT_INTR_SYNC_EN). INT_ACK -> FLG_SHAD_LD = 1 that cycle only; next cycle I_FLAG = 0, IN_SERVICE = 1, INT_REQ = 0.
- In SERVICE, RETI with RETI_IE = 1 -> FLG_LD_SEL/C_LD/Z_LD = 1 for one cycle; next cycle I_FLAG = 1, state IDLE. Repeat with RETI_IE = 0 -> I_FLAG = 0.
- I_FLAG = 0, INTR edge -> INT_REQ stays 0 for 10 cycles. SEI -> INT_REQ = 1 next cycle.
- In SERVICE, 3 INTR edges -> DROP_CNT = 2. RETI -> state PEND, INT_REQ = RETI_IE. Drive 300 extra edges -> DROP_CNT saturates at 255.
- Same cycle SEI and CLI -> I_FLAG = 0. Accepted ack plus SEI -> I_FLAG = 0. INT_ACK with INT_REQ = 0 -> no FLG_SHAD_LD and no state change.

Source files
------------

// File: rtl/rat_intr_pkg.sv
// Shared types for the RAT interrupt sequencer.
// Optional build macro RAT_INTR_SYNC_EN enables the INTR input synchronizer.
package rat_intr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PEND    = 2'd1,
        SERVICE = 2'd2
    } st_e;

    localparam int unsigned SYNC_DEPTH = 2;

endpackage

// File: rtl/rat_intr_sync.sv
// INTR conditioning: optional 2-flop synchronizer followed by a rising-edge detector.
// Build macro RAT_INTR_SYNC_EN: when undefined, INTR must already be synchronous to CLK.
module rat_intr_sync
    import rat_intr_pkg::*;
(
    input  logic CLK,
    input  logic RST_N,
    input  logic INTR,
    output logic INTR_EDGE
);

    logic intr_s;
    logic intr_s_d;

`ifdef RAT_INTR_SYNC_EN
    logic [SYNC_DEPTH-1:0] sync_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], INTR};
        end
    end

    assign intr_s = sync_q[SYNC_DEPTH-1];
`else
    assign intr_s = INTR;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            intr_s_d <= 1'b0;
        end else begin
            intr_s_d <= intr_s;
        end
    end

    assign INTR_EDGE = intr_s & ~intr_s_d;

endmodule

// File: rtl/rat_intr_ctrl.sv
// RAT CPU interrupt sequencer: latches INTR edges, requests service, drives flag shadow save/restore.
// Build macro RAT_INTR_SYNC_EN adds a 2-flop INTR synchronizer (+2 cycles request latency).
module rat_intr_ctrl
    import rat_intr_pkg::*;
#(
    parameter int unsigned DROP_W = 8
)
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              INTR,
    input  logic              SEI,
    input  logic              CLI,
    input  logic              INT_ACK,
    input  logic              RETI,
    input  logic              RETI_IE,
    output logic              INT_REQ,
    output logic              I_FLAG,
    output logic              IN_SERVICE,
    output logic              FLG_SHAD_LD,
    output logic              FLG_LD_SEL,
    output logic              FLG_C_LD,
    output logic              FLG_Z_LD,
    output logic [DROP_W-1:0] DROP_CNT
);

    st_e               state_q, state_d;
    logic              pend_q, pend_d;
    logic              i_flag_q, i_flag_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic intr_edge;
    logic int_req;
    logic ack_acc;
    logic reti_v;

    rat_intr_sync u_sync (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .INTR      (INTR),
        .INTR_EDGE (intr_edge)
    );

    assign int_req = (state_q == PEND) & i_flag_q;
    assign ack_acc = INT_ACK & int_req;
    assign reti_v  = RETI & (state_q == SERVICE);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            pend_q   <= 1'b0;
            i_flag_q <= 1'b0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            i_flag_q <= i_flag_d;
            drop_q   <= drop_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        i_flag_d = i_flag_q;
        drop_d   = drop_q;

        // an edge coinciding with an accepted ack is a fresh request, not a lost one
        if (intr_edge) begin
            pend_d = 1'b1;
        end else if (ack_acc) begin
            pend_d = 1'b0;
        end

        if (intr_edge && pend_q && !ack_acc && (drop_q != '1)) begin
            drop_d = drop_q + DROP_W'(1);
        end

        if (ack_acc) begin
            i_flag_d = 1'b0;
        end else if (reti_v) begin
            i_flag_d = RETI_IE;
        end else if (CLI) begin
            i_flag_d = 1'b0;
        end else if (SEI) begin
            i_flag_d = 1'b1;
        end

        // return from ISR goes straight to PEND if a request arrived meanwhile (or this cycle)
        unique case (state_q)
            IDLE:    if (intr_edge) state_d = PEND;
            PEND:    if (ack_acc)   state_d = SERVICE;
            SERVICE: if (reti_v)    state_d = pend_d ? PEND : IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign INT_REQ     = int_req;
    assign I_FLAG      = i_flag_q;
    assign IN_SERVICE  = (state_q == SERVICE);
    assign FLG_SHAD_LD = ack_acc;
    assign FLG_LD_SEL  = reti_v;
    assign FLG_C_LD    = reti_v;
    assign FLG_Z_LD    = reti_v;
    assign DROP_CNT    = drop_q;

endmodule

// File: tb/tb_rat_intr_ctrl.sv
// Self-checking bench for rat_intr_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_rat_intr_ctrl;

    localparam int unsigned DW = 8;
`ifdef RAT_INTR_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif
    localparam int D    = LAT - 1;
    localparam int DMAX = (1 << DW) - 1;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          INTR = 1'b0;
    logic          SEI = 1'b0;
    logic          CLI = 1'b0;
    logic          INT_ACK = 1'b0;
    logic          RETI = 1'b0;
    logic          RETI_IE = 1'b0;
    logic          INT_REQ, I_FLAG, IN_SERVICE, FLG_SHAD_LD, FLG_LD_SEL, FLG_C_LD, FLG_Z_LD;
    logic [DW-1:0] DROP_CNT;

    int n_checks = 0;
    int n_fail   = 0;

    rat_intr_ctrl #(.DROP_W(DW)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .INTR        (INTR),
        .SEI         (SEI),
        .CLI         (CLI),
        .INT_ACK     (INT_ACK),
        .RETI        (RETI),
        .RETI_IE     (RETI_IE),
        .INT_REQ     (INT_REQ),
        .I_FLAG      (I_FLAG),
        .IN_SERVICE  (IN_SERVICE),
        .FLG_SHAD_LD (FLG_SHAD_LD),
        .FLG_LD_SEL  (FLG_LD_SEL),
        .FLG_C_LD    (FLG_C_LD),
        .FLG_Z_LD    (FLG_Z_LD),
        .DROP_CNT    (DROP_CNT)
    );

    always #5 CLK = ~CLK;

    // Behavioural model: an ISR flag, a pending-request flag, the enable flag and a drop tally.
    bit       m_isr, m_pend, m_ien;
    int       m_drops;
    bit [3:0] m_hist;

    always @(posedge CLK or negedge RST_N) begin
        bit e, req, acc, rv;
        if (!RST_N) begin
            m_isr   = 0;
            m_pend  = 0;
            m_ien   = 0;
            m_drops = 0;
            m_hist  = '0;
        end else begin
            m_hist = {m_hist[2:0], INTR};
            e   = m_hist[D] && !m_hist[D+1];
            req = m_pend && !m_isr && m_ien;
            acc = INT_ACK && req;
            rv  = RETI && m_isr;
            if (e && m_pend && !acc) m_drops = (m_drops < DMAX) ? m_drops + 1 : DMAX;
            if (e) m_pend = 1;
            else if (acc) m_pend = 0;
            if (acc) m_ien = 0;
            else if (rv) m_ien = RETI_IE;
            else if (CLI) m_ien = 0;
            else if (SEI) m_ien = 1;
            if (acc) m_isr = 1;
            else if (rv) m_isr = 0;
        end
    end

    always @(negedge CLK) begin
        logic [DW+6:0] exp_v, act_v;
        bit req;
        req   = m_pend && !m_isr && m_ien;
        exp_v = {req, m_ien, m_isr, INT_ACK && req, {3{RETI && m_isr}}, DW'(m_drops)};
        act_v = {INT_REQ, I_FLAG, IN_SERVICE, FLG_SHAD_LD, FLG_LD_SEL, FLG_C_LD, FLG_Z_LD, DROP_CNT};
        n_checks++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL cycle_cmp t=%0t actual=%h expected=%h (req,i,svc,shad,sel,c,z,drop)",
                     $time, act_v, exp_v);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic cyc;
        @(posedge CLK);
        #1;
    endtask

    task automatic enter_service;
        INTR = 1'b0;
        cyc();
        INTR = 1'b1;
        repeat (LAT) cyc();
        INT_ACK = 1'b1;
        cyc();
        INT_ACK = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        #2;
        chk("rst_i_flag", int'(I_FLAG), 0);
        chk("rst_int_req", int'(INT_REQ), 0);
        chk("rst_drop", int'(DROP_CNT), 0);
        chk("model_rst_ien", int'(m_ien), 0);
        #21 RST_N = 1'b1;
        cyc();

        SEI = 1'b1; cyc(); SEI = 1'b0;
        #1 chk("sei_sets_i", int'(I_FLAG), 1);
        INTR = 1'b1;
        repeat (LAT-1) cyc();
        #1 chk("req_not_early", int'(INT_REQ), 0);
        cyc();
        #1 chk("req_latency", int'(INT_REQ), 1);

        INT_ACK = 1'b1;
        #1 chk("ack_shad_ld", int'(FLG_SHAD_LD), 1);
        cyc(); INT_ACK = 1'b0;
        #1;
        chk("shad_ld_one_cycle", int'(FLG_SHAD_LD), 0);
        chk("ack_clears_i", int'(I_FLAG), 0);
        chk("ack_in_service", int'(IN_SERVICE), 1);
        chk("no_nesting_req", int'(INT_REQ), 0);

        RETI = 1'b1; RETI_IE = 1'b1;
        #1;
        chk("reti_ld_sel", int'(FLG_LD_SEL), 1);
        chk("reti_c_ld", int'(FLG_C_LD), 1);
        chk("reti_z_ld", int'(FLG_Z_LD), 1);
        cyc(); RETI = 1'b0;
        #1;
        chk("reti_strobe_once", int'(FLG_LD_SEL), 0);
        chk("retie_sets_i", int'(I_FLAG), 1);
        chk("reti_to_idle", int'(IN_SERVICE), 0);
        chk("idle_no_req", int'(INT_REQ), 0);

        enter_service();
        #1 chk("second_service", int'(IN_SERVICE), 1);
        RETI = 1'b1; RETI_IE = 1'b0; cyc(); RETI = 1'b0;
        #1 chk("retid_clears_i", int'(I_FLAG), 0);

        INTR = 1'b0; cyc(); INTR = 1'b1;
        repeat (LAT + 10) cyc();
        #1 chk("masked_req_held", int'(INT_REQ), 0);
        SEI = 1'b1; cyc(); SEI = 1'b0;
        #1 chk("sei_releases_req", int'(INT_REQ), 1);

        INT_ACK = 1'b1; cyc(); INT_ACK = 1'b0;
        #1 chk("svc_for_drops", int'(IN_SERVICE), 1);
        repeat (3) begin
            INTR = 1'b0; cyc();
            INTR = 1'b1; cyc();
        end
        repeat (LAT) cyc();
        #1 chk("drop_two", int'(DROP_CNT), 2);
        RETI = 1'b1; RETI_IE = 1'b1; cyc(); RETI = 1'b0;
        #1;
        chk("reti_back_to_pend", int'(INT_REQ), 1);
        chk("reti_leaves_svc", int'(IN_SERVICE), 0);
        repeat (300) begin
            INTR = 1'b0; cyc();
            INTR = 1'b1; cyc();
        end
        repeat (LAT) cyc();
        #1;
        chk("drop_saturate", int'(DROP_CNT), 255);
        chk("model_drop_saturate", m_drops, 255);

        SEI = 1'b1; CLI = 1'b1; cyc(); SEI = 1'b0; CLI = 1'b0;
        #1 chk("cli_beats_sei", int'(I_FLAG), 0);
        INT_ACK = 1'b1;
        #1 chk("ignored_ack_no_shad", int'(FLG_SHAD_LD), 0);
        cyc(); INT_ACK = 1'b0;
        #1 chk("ignored_ack_no_svc", int'(IN_SERVICE), 0);
        SEI = 1'b1; cyc(); SEI = 1'b0;
        #1 chk("pend_req_after_sei", int'(INT_REQ), 1);
        INT_ACK = 1'b1; SEI = 1'b1; cyc(); INT_ACK = 1'b0; SEI = 1'b0;
        #1;
        chk("ack_beats_sei", int'(I_FLAG), 0);
        chk("ack_sei_in_service", int'(IN_SERVICE), 1);

        RETI = 1'b1; RETI_IE = 1'b1;
        #1 chk("pre_reset_restore", int'(FLG_LD_SEL), 1);
        RST_N = 1'b0;
        #1;
        chk("async_rst_svc", int'(IN_SERVICE), 0);
        chk("async_rst_i", int'(I_FLAG), 0);
        chk("async_rst_drop", int'(DROP_CNT), 0);
        chk("async_rst_req", int'(INT_REQ), 0);
        chk("async_rst_shad", int'(FLG_SHAD_LD), 0);
        chk("async_rst_ld_sel", int'(FLG_LD_SEL), 0);
        chk("async_rst_c_ld", int'(FLG_C_LD), 0);
        chk("async_rst_z_ld", int'(FLG_Z_LD), 0);
        RETI = 1'b0;
        #10 RST_N = 1'b1;
        cyc();

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) INTR = ~INTR;
            SEI     = ($urandom_range(0, 7) == 0);
            CLI     = ($urandom_range(0, 15) == 0);
            INT_ACK = ($urandom_range(0, 2) == 0);
            RETI    = ($urandom_range(0, 5) == 0);
            RETI_IE = 1'($urandom_range(0, 1));
            if (i % 1000 == 999) begin
                #1 RST_N = 1'b0;
                #2 RST_N = 1'b1;
            end
            cyc();
        end

        INTR = 1'b0; SEI = 1'b0; CLI = 1'b0; INT_ACK = 1'b0; RETI = 1'b0;
        cyc();
        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
